// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back controller.
// Holds default widths and the requester IDs that the round-robin pointer uses.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 2 ** ADDR_W_DEF;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending-write scoreboard: one busy flop per register,
// set by destination allocation, cleared by the committing write.
module regfile_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int DROP_R0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [ADDR_W-1:0]        rd0_addr,
    input  logic [ADDR_W-1:0]        rd1_addr,
    output logic                     rd0_busy,
    output logic                     rd1_busy,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] set_vec_s;
    logic [NREG-1:0] clr_vec_s;
    logic [NREG-1:0] busy_nxt_s;

    // Next busy state: OR-in after masking so a same-edge set beats the clear.
    always_comb begin
        set_vec_s  = {NREG{1'b0}};
        clr_vec_s  = {NREG{1'b0}};
        if (set_en) begin
            set_vec_s = {{(NREG-1){1'b0}}, 1'b1} << set_addr;
        end else begin
            set_vec_s = {NREG{1'b0}};
        end
        if (clr_en) begin
            clr_vec_s = {{(NREG-1){1'b0}}, 1'b1} << clr_addr;
        end else begin
            clr_vec_s = {NREG{1'b0}};
        end
        busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
        if (DROP_R0 != 0) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s[0] = busy_nxt_s[0];
        end
    end

    // Busy flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign rd0_busy = busy_r[rd0_addr];
    assign rd1_busy = busy_r[rd1_addr];
    assign busy_vec = busy_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin arbitration of ALU and load results onto
// the single register-file write port, plus the pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DROP_R0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    input  logic                     mark_valid,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic [ADDR_W-1:0]        A3,
    output logic                     WE3,
    output logic [DATA_W-1:0]        WD3
);

    logic              prio_r;
    logic              grant0_s;
    logic              grant1_s;
    logic              hs_s;
    logic              drop_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

    // Round-robin grant; prio only matters when both requesters are valid.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (prio_r == REQ_ALU) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Granted payload mux and register-0 drop detection.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        if (grant1_s) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
        end
        hs_s   = grant0_s | grant1_s;
        drop_s = (DROP_R0 != 0) && (sel_addr_s == {ADDR_W{1'b0}});
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Write-port output register and priority pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_r <= REQ_ALU;
            A3     <= {ADDR_W{1'b0}};
            WD3    <= {DATA_W{1'b0}};
            WE3    <= 1'b0;
        end else if (hs_s) begin
            prio_r <= grant0_s ? REQ_LD : REQ_ALU;
            A3     <= sel_addr_s;
            WD3    <= sel_data_s;
            WE3    <= ~drop_s;
        end else begin
            WE3    <= 1'b0;
        end
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .DROP_R0 (DROP_R0)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (mark_valid),
        .set_addr (mark_addr),
        .clr_en   (WE3),
        .clr_addr (A3),
        .rd0_addr (rs1_addr),
        .rd1_addr (rs2_addr),
        .rd0_busy (rs1_busy),
        .rd1_busy (rs2_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, mark_valid = 1'b0;
    logic [4:0]  req0_addr = 5'd0, req1_addr = 5'd0, mark_addr = 5'd0;
    logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0;
    logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
    logic        req0_ready, req1_ready, rs1_busy, rs2_busy, WE3;
    logic [31:0] busy_vec, WD3;
    logic [4:0]  A3;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model state: what the registered outputs must be after each edge.
    bit          m_prio;
    bit          m_we;
    bit [4:0]    m_a;
    bit [31:0]   m_d;
    bit          m_busy [32];

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec), .A3(A3), .WE3(WE3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_grant1();
        if (req0_valid && req1_valid) return m_prio;
        return req1_valid && !req0_valid;
    endfunction

    // Behavioural model: advance on every edge using the inputs seen there.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prio = 1'b0; m_we = 1'b0; m_a = 5'd0; m_d = 32'd0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            bit g1, any;
            g1  = model_grant1();
            any = req0_valid || req1_valid;
            if (m_we) m_busy[m_a] = 1'b0;
            if (mark_valid) m_busy[mark_addr] = 1'b1;
            m_busy[0] = 1'b0;
            if (any) begin
                m_a    = g1 ? req1_addr : req0_addr;
                m_d    = g1 ? req1_data : req0_data;
                m_we   = (m_a != 5'd0);
                m_prio = !g1;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            bit [31:0] ev;
            bit any;
            any = req0_valid || req1_valid;
            for (int i = 0; i < 32; i++) ev[i] = m_busy[i];
            chk("m_ready0", {63'd0, req0_ready}, {63'd0, any && !model_grant1()});
            chk("m_ready1", {63'd0, req1_ready}, {63'd0, any && model_grant1()});
            chk("m_we3", {63'd0, WE3}, {63'd0, m_we});
            if (m_we) begin
                chk("m_a3", {59'd0, A3}, {59'd0, m_a});
                chk("m_wd3", {32'd0, WD3}, {32'd0, m_d});
            end
            chk("m_busy_vec", {32'd0, busy_vec}, {32'd0, ev});
            chk("m_rs1_busy", {63'd0, rs1_busy}, {63'd0, m_busy[rs1_addr]});
            chk("m_rs2_busy", {63'd0, rs2_busy}, {63'd0, m_busy[rs2_addr]});
        end
    end

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; mark_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_a3", {59'd0, A3}, 64'd0);
        chk("rst_wd3", {32'd0, WD3}, 64'd0);
        chk("rst_we3", {63'd0, WE3}, 64'd0);
        chk("rst_busy", {32'd0, busy_vec}, 64'd0);
        cmp_en = 1'b1;

        // Single writer.
        drive_next();
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'd31;
        @(negedge clk); chk("sw_ready", {63'd0, req0_ready}, 64'd1);
        drive_next(); idle();
        @(negedge clk);
        chk("sw_a3", {59'd0, A3}, 64'd10);
        chk("sw_wd3", {32'd0, WD3}, 64'd31);
        chk("sw_we3", {63'd0, WE3}, 64'd1);
        drive_next();
        @(negedge clk); chk("sw_we3_off", {63'd0, WE3}, 64'd0);

        // Reset while a handshake is in flight.
        drive_next();
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'd31;
        @(negedge clk);
        reset = 1'b1;
        drive_next();
        idle(); reset = 1'b0;
        @(negedge clk);
        chk("rmw_we3", {63'd0, WE3}, 64'd0);
        chk("rmw_busy", {32'd0, busy_vec}, 64'd0);

        // Contention: grants alternate starting with req0 after reset.
        for (int k = 0; k < 5; k++) begin
            drive_next();
            if (k < 4) begin
                req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hAA + k;
                req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hBB + k;
            end else begin
                idle();
            end
            @(negedge clk);
            if (k < 4) chk("ct_ready0", {63'd0, req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("ct_we3", {63'd0, WE3}, 64'd1);
                chk("ct_a3", {59'd0, A3}, (k % 2 == 1) ? 64'd1 : 64'd2);
            end
        end

        // Scoreboard: mark 5, write it, re-mark in the WE3 cycle.
        drive_next(); mark_valid = 1'b1; mark_addr = 5'd5; rs1_addr = 5'd5;
        @(negedge clk); chk("sb_before", {63'd0, rs1_busy}, 64'd0);
        drive_next(); mark_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h55;
        @(negedge clk);
        chk("sb_marked", {63'd0, rs1_busy}, 64'd1);
        chk("sb_ready1", {63'd0, req1_ready}, 64'd1);
        drive_next(); req1_valid = 1'b0; mark_valid = 1'b1; mark_addr = 5'd5;
        @(negedge clk);
        chk("sb_we3", {63'd0, WE3}, 64'd1);
        chk("sb_a3", {59'd0, A3}, 64'd5);
        chk("sb_busy_we", {63'd0, rs1_busy}, 64'd1);
        drive_next(); mark_valid = 1'b0;
        @(negedge clk); chk("sb_set_wins", {63'd0, rs1_busy}, 64'd1);
        drive_next(); req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h77;
        drive_next(); idle();
        @(negedge clk); chk("sb_busy_we2", {63'd0, rs1_busy}, 64'd1);
        drive_next();
        @(negedge clk); chk("sb_free", {63'd0, rs1_busy}, 64'd0);

        // Register 0 is dropped but the handshake completes.
        drive_next();
        mark_valid = 1'b1; mark_addr = 5'd0; rs2_addr = 5'd0;
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF;
        @(negedge clk); chk("r0_ready", {63'd0, req0_ready}, 64'd1);
        drive_next(); idle();
        @(negedge clk);
        chk("r0_we3", {63'd0, WE3}, 64'd0);
        chk("r0_busy0", {63'd0, busy_vec[0]}, 64'd0);
        chk("r0_rs2", {63'd0, rs2_busy}, 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive_next();
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            mark_valid = ($urandom_range(0, 2) == 0);
            req0_addr  = $urandom_range(0, 7);
            req1_addr  = $urandom_range(0, 7);
            mark_addr  = $urandom_range(0, 7);
            rs1_addr   = $urandom_range(0, 7);
            rs2_addr   = $urandom_range(0, 31);
            req0_data  = $urandom;
            req1_data  = $urandom;
        end
        drive_next(); idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 register file. Shares the single write port (A3/WE3/WD3) between two writers, ALU result (req0) and load result (req1), using valid/ready handshakes and round-robin priority. Also keeps a per-register pending-write scoreboard, so issue logic can stall reads (A1/A2) whose source register still has a write in flight. Sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width; NREG = 2**ADDR_W
DROP_R0, 1, when 1 register 0 is never written and never marked busy

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  ALU write request
req0_ready  out  1  ALU request accepted this cycle
req0_addr  in  ADDR_W  ALU destination register
req0_data  in  DATA_W  ALU result
req1_valid  in  1  load write request
req1_ready  out  1  load request accepted this cycle
req1_addr  in  ADDR_W  load destination register
req1_data  in  DATA_W  load data
mark_valid  in  1  issue stage allocates a destination
mark_addr  in  ADDR_W  register to mark pending
rs1_addr  in  ADDR_W  first source being read
rs2_addr  in  ADDR_W  second source being read
rs1_busy  out  1  rs1 has a pending write
rs2_busy  out  1  rs2 has a pending write
busy_vec  out  NREG  scoreboard contents
A3  out  ADDR_W  register file write address
WE3  out  1  register file write enable
WD3  out  DATA_W  register file write data

Behaviour:
- Reset (async, active-high): A3=0, WD3=0, WE3=0, busy_vec=0, prio=0 (req0 favoured). Reset during an in-flight write drops that write.
- Arbitration (combinational): exactly one of reqN_ready goes high when any valid is high.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester equal to prio is granted.
- A handshake is valid AND ready in the same cycle.
- prio update: after any grant, prio is set to the other requester. With no grant, prio holds.
- Output register: on a handshake, A3/WD3 load the granted addr/data at the next edge, and WE3=1 for exactly that one cycle. The register file commits at the following edge. Latency from handshake to WE3 high is 1 cycle. Sustained throughput is 1 write per cycle, with no bubbles between back-to-back grants.
- No handshake: WE3=0. A3/WD3 hold their last values.
- DROP_R0=1 and granted addr=0: the handshake still completes (ready=1), but WE3 stays 0.
- Scoreboard:
  - mark_valid sets busy[mark_addr] at the edge.
  - busy[A3] clears at the edge ending a cycle where WE3=1.
  - Set and clear on the same register in the same edge: set wins, because a new producer has been allocated.
  - DROP_R0=1: busy[0] is forced to 0.
- rsN_busy = busy_vec[rsN_addr], combinational. There is no bypass: a register reads as busy through the cycle its WE3 is high and is free the next cycle.
- Writing a register that was never marked is legal and leaves busy at 0.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, NREG, and the localparam encoding of requester IDs (REQ_ALU=0, REQ_LD=1).
- One sub-module, regfile_scoreboard: busy flops, set/clear logic, two read taps. The arbiter and output register remain in the top level.

Test Plan:
- Reset mid-write: req0 addr=10 data=31 accepted, reset asserted before the next edge -> WE3 stays 0, busy_vec=0, prio=0.
- Single writer: req0 addr=10 data=31 -> req0_ready=1 the same cycle; next cycle A3=10, WD3=31, WE3=1; then WE3=0.
- Contention: both valid every cycle, req0 (addr1, 0xAA) and req1 (addr2, 0xBB) with fresh data per cycle -> grants alternate 0,1,0,1; WE3 is high every cycle; A3 sequence is 1,2,1,2.
- Scoreboard: mark 5, then req1 addr=5 accepted with rs1_addr=5 -> rs1_busy=1 from the cycle after the mark through the WE3 cycle, 0 afterwards. Mark 5 again in the WE3 cycle -> busy stays 1.
- Register 0: mark_valid addr=0, req0 addr=0 data=0xFFFF -> req0_ready=1, WE3 stays 0, busy_vec[0]=0, rs2_busy=0 for rs2_addr=0.
